// File: rtl/exc_pkg.sv
// Shared constants for the exception/interrupt arbiter: MIPS ExcCodes,
// FSM state encoding and the default exception entry vector.
package exc_pkg;

  // Cause.ExcCode values reported by the pipeline stages
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OVF  = 5'd12;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMMIT  = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_ERET    = 2'd3;

  // General exception entry address
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

endpackage

// File: rtl/exc_prio_sel.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set
// request bit and a one-hot grant (all zero when nothing is requested).
module exc_prio_sel
  import exc_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     grant
);

  // Scan from the top down so the lowest requesting index is the last writer
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path can
    // leave it unassigned and infer a latch.
    idx   = '0;
    grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx      = IDX_W'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_arbiter_n.sv
// Registered exception/interrupt arbiter. Picks the oldest excepting stage
// (or a pending enabled interrupt), commits it for exactly one cycle
// (CP0 write, flush, redirect to the vector), then tracks handler residency
// until ERET, which flushes and redirects to EPC for one cycle.
module exc_arbiter_n
  import exc_pkg::*;
#(
  parameter int              NUM_STAGES = 3,
  parameter int              NUM_HWINT  = 6,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DEFAULT),
  parameter int              CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_STAGES-1:0]      exc_valid,
  input  logic [5*NUM_STAGES-1:0]    exc_code,
  input  logic [PC_W*NUM_STAGES-1:0] exc_pc,
  input  logic [NUM_STAGES-1:0]      exc_bd,
  input  logic [PC_W-1:0]            int_pc,
  input  logic                       int_bd,
  input  logic [NUM_HWINT-1:0]       hw_int,
  input  logic                       cp0_status_ie,
  input  logic                       cp0_status_exl,
  input  logic [NUM_HWINT-1:0]       cp0_status_im,
  input  logic [PC_W-1:0]            cp0_epc_in,
  input  logic                       eret,
  output logic                       cp0_we,
  output logic                       cp0_epc_we,
  output logic [4:0]                 cp0_exccode,
  output logic [PC_W-1:0]            cp0_epc,
  output logic                       cp0_bd,
  output logic [NUM_HWINT-1:0]       cp0_ip,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [PC_W-1:0]            redirect_pc,
  output logic                       in_handler,
  output logic [CNT_W-1:0]           exc_count
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [1:0]            state;
  logic                  epc_we_pending;
  logic [NUM_HWINT-1:0]  hw_int_meta;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_STAGES-1:0] win_grant;
  logic                  exc_any;
  logic                  int_req;
  logic                  is_commit;
  logic                  is_eret;
  logic [4:0]            stage_code [NUM_STAGES];
  logic [PC_W-1:0]       stage_pc   [NUM_STAGES];
  logic [4:0]            sel_code;
  logic [PC_W-1:0]       sel_pc;
  logic                  sel_bd;
  logic [PC_W-1:0]       sel_epc;

  exc_prio_sel #(
    .N     (NUM_STAGES),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (exc_valid),
    .idx   (win_idx),
    .grant (win_grant)
  );

  assign exc_any = |win_grant;

  // Unpack the flat per-stage buses so the winner can be indexed directly
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_code[i] = exc_code[5*i +: 5];
      stage_pc[i]   = exc_pc[PC_W*i +: PC_W];
    end
  end

  // Winner fields: oldest excepting stage, else the interrupt restart point
  always_comb begin
    sel_code = EXC_INT;
    sel_pc   = int_pc;
    sel_bd   = int_bd;
    if (exc_any) begin
      sel_code = stage_code[win_idx];
      sel_pc   = stage_pc[win_idx];
      sel_bd   = exc_bd[win_idx];
    end
  end

  // A delay-slot fault restarts at the branch, one word earlier
  assign sel_epc = sel_bd ? sel_pc - PC_W'(4) : sel_pc;

  assign int_req = (|(cp0_ip & cp0_status_im)) & cp0_status_ie &
                   ~cp0_status_exl & (state == ST_IDLE);

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so each flop
    // samples the pre-edge value of the one before it.
    if (!resetn) begin
      hw_int_meta <= '0;
      cp0_ip      <= '0;
    end else begin
      hw_int_meta <= hw_int;
      cp0_ip      <= hw_int_meta;
    end
  end

  // FSM, winner capture and saturating commit counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      epc_we_pending <= 1'b0;
      cp0_exccode    <= '0;
      cp0_epc        <= '0;
      cp0_bd         <= 1'b0;
      exc_count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exc_any || int_req) begin
            state          <= ST_COMMIT;
            epc_we_pending <= 1'b1;
            cp0_exccode    <= sel_code;
            cp0_epc        <= sel_epc;
            cp0_bd         <= sel_bd;
          end else if (eret) begin
            state <= ST_ERET;
          end
        end
        ST_COMMIT: begin
          state <= ST_HANDLER;
          if (exc_count != '1) exc_count <= exc_count + CNT_W'(1);
        end
        ST_HANDLER: begin
          // Nested exception keeps the original EPC/BD, only the code moves
          if (exc_any) begin
            state          <= ST_COMMIT;
            epc_we_pending <= 1'b0;
            cp0_exccode    <= sel_code;
          end else if (eret) begin
            state <= ST_ERET;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign is_commit      = (state == ST_COMMIT);
  assign is_eret        = (state == ST_ERET);
  assign in_handler     = (state == ST_HANDLER);
  assign cp0_we         = is_commit;
  assign cp0_epc_we     = is_commit & epc_we_pending;
  assign flush          = is_commit | is_eret;
  assign redirect_valid = is_commit | is_eret;

  // Redirect target: vector on commit, live EPC on return, else zero
  always_comb begin
    redirect_pc = '0;
    if (is_commit)    redirect_pc = EXC_VECTOR;
    else if (is_eret) redirect_pc = cp0_epc_in;
  end

endmodule

// File: tb/tb_exc_arbiter_n.sv
// Self-checking bench for exc_arbiter_n: directed scenarios plus a random
// run compared cycle by cycle against a behavioural model.
module tb_exc_arbiter_n;
  import exc_pkg::*;

  localparam int          NS  = 3;
  localparam int          NH  = 6;
  localparam int          PW  = 32;
  localparam logic [31:0] VEC = 32'h8000_0180;

  typedef enum {M_IDLE, M_COMMIT, M_HANDLER, M_ERET} mode_t;

  logic            clk;
  logic            resetn;
  logic [NS-1:0]   exc_valid;
  logic [5*NS-1:0] exc_code;
  logic [PW*NS-1:0] exc_pc;
  logic [NS-1:0]   exc_bd;
  logic [PW-1:0]   int_pc;
  logic            int_bd;
  logic [NH-1:0]   hw_int;
  logic            cp0_status_ie, cp0_status_exl;
  logic [NH-1:0]   cp0_status_im;
  logic [PW-1:0]   cp0_epc_in;
  logic            eret;

  logic            cp0_we, cp0_epc_we, cp0_bd, flush, redirect_valid, in_handler;
  logic [4:0]      cp0_exccode;
  logic [PW-1:0]   cp0_epc, redirect_pc;
  logic [NH-1:0]   cp0_ip;
  logic [15:0]     exc_count;

  logic            s_we, s_epc_we, s_bd, s_flush, s_rv, s_in_handler;
  logic [4:0]      s_exccode;
  logic [PW-1:0]   s_epc, s_rpc;
  logic [NH-1:0]   s_ip;
  logic [3:0]      s_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  mode_t         m_mode;
  logic [4:0]    m_code;
  logic [31:0]   m_epc;
  logic          m_bd, m_pend;
  int            m_commits;
  logic [NH-1:0] m_ip;
  logic [NH-1:0] m_hq[$];

  exc_arbiter_n #(.NUM_STAGES(NS), .NUM_HWINT(NH), .PC_W(PW), .EXC_VECTOR(VEC), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .int_pc(int_pc), .int_bd(int_bd), .hw_int(hw_int),
    .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl), .cp0_status_im(cp0_status_im),
    .cp0_epc_in(cp0_epc_in), .eret(eret), .cp0_we(cp0_we), .cp0_epc_we(cp0_epc_we),
    .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd), .cp0_ip(cp0_ip),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .in_handler(in_handler), .exc_count(exc_count));

  // Narrow-counter twin so saturation is reachable in a few dozen cycles
  exc_arbiter_n #(.NUM_STAGES(NS), .NUM_HWINT(NH), .PC_W(PW), .EXC_VECTOR(VEC), .CNT_W(4)) dut_sat (
    .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .int_pc(int_pc), .int_bd(int_bd), .hw_int(hw_int),
    .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl), .cp0_status_im(cp0_status_im),
    .cp0_epc_in(cp0_epc_in), .eret(eret), .cp0_we(s_we), .cp0_epc_we(s_epc_we),
    .cp0_exccode(s_exccode), .cp0_epc(s_epc), .cp0_bd(s_bd), .cp0_ip(s_ip),
    .flush(s_flush), .redirect_valid(s_rv), .redirect_pc(s_rpc),
    .in_handler(s_in_handler), .exc_count(s_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    int first;
    logic [31:0] pc;
    bit irq;
    if (!resetn) begin
      m_mode = M_IDLE; m_code = '0; m_epc = '0; m_bd = 1'b0; m_pend = 1'b0;
      m_commits = 0; m_ip = '0; m_hq.delete();
    end else begin
      first = -1;
      for (int i = NS - 1; i >= 0; i--) if (exc_valid[i]) first = i;
      irq = (m_mode == M_IDLE) && ((m_ip & cp0_status_im) != '0) && cp0_status_ie && !cp0_status_exl;
      case (m_mode)
        M_IDLE: begin
          if (first >= 0) begin
            m_code = exc_code[5*first +: 5];
            pc     = exc_pc[PW*first +: PW];
            m_bd   = exc_bd[first];
            m_epc  = m_bd ? pc - 32'd4 : pc;
            m_pend = 1'b1; m_mode = M_COMMIT;
          end else if (irq) begin
            m_code = 5'd0; m_bd = int_bd;
            m_epc  = int_bd ? int_pc - 32'd4 : int_pc;
            m_pend = 1'b1; m_mode = M_COMMIT;
          end else if (eret) m_mode = M_ERET;
        end
        M_COMMIT: begin m_commits++; m_mode = M_HANDLER; end
        M_HANDLER: begin
          if (first >= 0) begin
            m_code = exc_code[5*first +: 5]; m_pend = 1'b0; m_mode = M_COMMIT;
          end else if (eret) m_mode = M_ERET;
        end
        M_ERET: m_mode = M_IDLE;
      endcase
      m_hq.push_back(hw_int);
      if (m_hq.size() > 2) void'(m_hq.pop_front());
      m_ip = (m_hq.size() == 2) ? m_hq[0] : '0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stage(input int i, input logic [4:0] code, input logic [31:0] pc, input logic bd);
    exc_code[5*i +: 5] = code;
    exc_pc[PW*i +: PW] = pc;
    exc_bd[i]          = bd;
  endtask

  task automatic enter_handler(input logic [4:0] code, input logic [31:0] pc);
    set_stage(0, code, pc, 1'b0);
    exc_valid = 3'b001; tick();
    exc_valid = 3'b000; tick();
  endtask

  task automatic exit_handler();
    exc_valid = '0;
    eret = 1'b1; tick();
    eret = 1'b0; tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; exc_valid = '0; exc_code = '0; exc_pc = '0; exc_bd = '0;
    int_pc = '0; int_bd = 1'b0; hw_int = '0; cp0_status_ie = 1'b0; cp0_status_exl = 1'b0;
    cp0_status_im = '0; cp0_epc_in = '0; eret = 1'b0;
    tick(); tick();
    n_tests++;
    if ({cp0_we, cp0_epc_we, cp0_exccode, cp0_epc, cp0_bd, cp0_ip, flush, redirect_valid, redirect_pc, in_handler, exc_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got we=%b ew=%b code=%0d epc=%h bd=%b ip=%b fl=%b rv=%b rpc=%h h=%b cnt=%0d, want all 0",
        cp0_we, cp0_epc_we, cp0_exccode, cp0_epc, cp0_bd, cp0_ip, flush, redirect_valid, redirect_pc, in_handler, exc_count);
    end
    resetn = 1'b1;
  endtask

  task automatic test_exc_priority();
    set_stage(0, 5'd4, 32'h0000_0100, 1'b0);
    set_stage(1, 5'd12, 32'h0000_0400, 1'b0);
    set_stage(2, 5'd10, 32'h0000_0500, 1'b0);
    exc_valid = 3'b110;
    tick();
    exc_valid = '0;
    n_tests++; if (cp0_exccode !== 5'd12) begin n_fail++; $display("FAIL prio_code: got %0d want 12", cp0_exccode); end
    n_tests++; if (cp0_epc !== 32'h400) begin n_fail++; $display("FAIL prio_epc: got %h want 00000400", cp0_epc); end
    n_tests++; if (cp0_epc_we !== 1'b1 || cp0_we !== 1'b1) begin n_fail++; $display("FAIL prio_we: got we=%b epc_we=%b want 1 1", cp0_we, cp0_epc_we); end
    n_tests++; if (flush !== 1'b1 || redirect_valid !== 1'b1) begin n_fail++; $display("FAIL prio_flush: got flush=%b rv=%b want 1 1", flush, redirect_valid); end
    n_tests++; if (redirect_pc !== VEC) begin n_fail++; $display("FAIL prio_rpc: got %h want %h", redirect_pc, VEC); end
    tick();
    n_tests++; if (in_handler !== 1'b1 || exc_count !== 16'd1) begin n_fail++; $display("FAIL prio_handler: got h=%b cnt=%0d want 1 1", in_handler, exc_count); end
    n_tests++; if (flush !== 1'b0 || cp0_we !== 1'b0) begin n_fail++; $display("FAIL prio_pulse_len: got flush=%b we=%b want 0 0", flush, cp0_we); end
    exit_handler();
  endtask

  task automatic test_exc_bd();
    set_stage(0, 5'd4, 32'h0000_1000, 1'b1);
    exc_valid = 3'b001;
    tick();
    exc_valid = '0;
    n_tests++; if (cp0_epc !== 32'hFFC || cp0_bd !== 1'b1) begin n_fail++; $display("FAIL bd_epc: got epc=%h bd=%b want 00000ffc 1", cp0_epc, cp0_bd); end
    n_tests++; if (cp0_exccode !== 5'd4) begin n_fail++; $display("FAIL bd_code: got %0d want 4", cp0_exccode); end
    tick();
    exit_handler();
    set_stage(0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic test_interrupt();
    hw_int = 6'b000100; cp0_status_im = 6'b000100; cp0_status_ie = 1'b1; cp0_status_exl = 1'b0;
    int_pc = 32'h2000; int_bd = 1'b0;
    tick();
    n_tests++; if (cp0_we !== 1'b0) begin n_fail++; $display("FAIL int_early1: got we=%b want 0", cp0_we); end
    tick();
    n_tests++; if (cp0_ip !== 6'b000100 || cp0_we !== 1'b0) begin n_fail++; $display("FAIL int_sync: got ip=%b we=%b want 000100 0", cp0_ip, cp0_we); end
    tick();
    n_tests++; if (cp0_we !== 1'b1 || cp0_epc_we !== 1'b1) begin n_fail++; $display("FAIL int_commit: got we=%b ew=%b want 1 1", cp0_we, cp0_epc_we); end
    n_tests++; if (cp0_exccode !== 5'd0 || cp0_epc !== 32'h2000 || cp0_bd !== 1'b0) begin
      n_fail++; $display("FAIL int_fields: got code=%0d epc=%h bd=%b want 0 00002000 0", cp0_exccode, cp0_epc, cp0_bd); end
    hw_int = '0;
    tick();
    exit_handler();
    // Same line with its mask bit cleared must never commit
    cp0_status_im = '0; hw_int = 6'b000100;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++; if (cp0_we !== 1'b0) begin n_fail++; $display("FAIL int_masked: got we=%b want 0 (cycle %0d)", cp0_we, k); end
    end
    hw_int = '0; cp0_status_ie = 1'b0;
    tick(); tick();
  endtask

  task automatic test_nested();
    enter_handler(5'd8, 32'h0000_1234);
    hw_int = 6'b000001; cp0_status_im = 6'b111111; cp0_status_ie = 1'b1; cp0_status_exl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if (cp0_we !== 1'b0 || in_handler !== 1'b1) begin n_fail++; $display("FAIL nest_int_blocked: got we=%b h=%b want 0 1", cp0_we, in_handler); end
    end
    set_stage(1, 5'd10, 32'h0000_9990, 1'b0);
    exc_valid = 3'b010;
    tick();
    exc_valid = '0;
    n_tests++; if (cp0_we !== 1'b1 || cp0_epc_we !== 1'b0) begin n_fail++; $display("FAIL nest_we: got we=%b ew=%b want 1 0", cp0_we, cp0_epc_we); end
    n_tests++; if (cp0_exccode !== 5'd10 || cp0_epc !== 32'h1234) begin n_fail++; $display("FAIL nest_fields: got code=%0d epc=%h want 10 00001234", cp0_exccode, cp0_epc); end
    tick();
    n_tests++; if (in_handler !== 1'b1) begin n_fail++; $display("FAIL nest_back: got h=%b want 1", in_handler); end
    hw_int = '0; cp0_status_ie = 1'b0;
    exit_handler();
  endtask

  task automatic test_eret();
    enter_handler(5'd9, 32'h0000_0040);
    eret = 1'b1; cp0_epc_in = 32'h3004;
    tick();
    eret = 1'b0;
    n_tests++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h3004) begin
      n_fail++; $display("FAIL eret_redirect: got fl=%b rv=%b rpc=%h want 1 1 00003004", flush, redirect_valid, redirect_pc); end
    n_tests++; if (cp0_we !== 1'b0 || cp0_epc_we !== 1'b0 || in_handler !== 1'b0) begin
      n_fail++; $display("FAIL eret_quiet: got we=%b ew=%b h=%b want 0 0 0", cp0_we, cp0_epc_we, in_handler); end
    tick();
    n_tests++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || in_handler !== 1'b0) begin
      n_fail++; $display("FAIL eret_idle: got fl=%b rv=%b h=%b want 0 0 0", flush, redirect_valid, in_handler); end
    // ERET colliding with a new exception: the exception wins
    enter_handler(5'd9, 32'h0000_0040);
    eret = 1'b1; set_stage(0, 5'd5, 32'h0000_0088, 1'b0); exc_valid = 3'b001;
    tick();
    eret = 1'b0; exc_valid = '0;
    n_tests++; if (cp0_we !== 1'b1 || redirect_pc !== VEC || cp0_exccode !== 5'd5) begin
      n_fail++; $display("FAIL eret_collide: got we=%b rpc=%h code=%0d want 1 %h 5", cp0_we, redirect_pc, cp0_exccode, VEC); end
    tick();
    n_tests++; if (in_handler !== 1'b1) begin n_fail++; $display("FAIL eret_dropped: got h=%b want 1", in_handler); end
    exit_handler();
  endtask

  task automatic test_reset_in_commit();
    set_stage(0, 5'd12, 32'h0000_0500, 1'b0);
    exc_valid = 3'b001;
    tick();
    exc_valid = '0;
    n_tests++; if (cp0_we !== 1'b1) begin n_fail++; $display("FAIL rstc_pre: got we=%b want 1", cp0_we); end
    resetn = 1'b0;
    tick();
    n_tests++;
    if ({cp0_we, cp0_epc_we, cp0_exccode, cp0_epc, cp0_bd, cp0_ip, flush, redirect_valid, redirect_pc, in_handler, exc_count} !== '0) begin
      n_fail++; $display("FAIL rstc_outputs: got we=%b ew=%b code=%0d epc=%h fl=%b rv=%b rpc=%h h=%b cnt=%0d want all 0",
        cp0_we, cp0_epc_we, cp0_exccode, cp0_epc, flush, redirect_valid, redirect_pc, in_handler, exc_count);
    end
    resetn = 1'b1;
    tick();
    n_tests++; if (in_handler !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rstc_idle: got h=%b fl=%b want 0 0", in_handler, flush); end
  endtask

  task automatic test_saturation();
    int guard;
    set_stage(0, 5'd9, 32'h0000_0700, 1'b0);
    exc_valid = 3'b001;
    guard = 0;
    while (!(m_commits == 15 && m_mode == M_HANDLER) && guard < 200) begin tick(); guard++; end
    n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL sat_timeout15: got %0d commits want 15", m_commits); end
    n_tests++; if (s_count !== 4'hF || exc_count !== 16'd15) begin n_fail++; $display("FAIL sat_reach: got narrow=%h wide=%0d want f 15", s_count, exc_count); end
    guard = 0;
    while (!(m_commits == 16 && m_mode == M_HANDLER) && guard < 20) begin tick(); guard++; end
    n_tests++; if (guard >= 20) begin n_fail++; $display("FAIL sat_timeout16: got %0d commits want 16", m_commits); end
    n_tests++; if (s_count !== 4'hF || exc_count !== 16'd16) begin n_fail++; $display("FAIL sat_hold: got narrow=%h wide=%0d want f 16", s_count, exc_count); end
    exit_handler();
  endtask

  task automatic test_random();
    logic [80:0] exp_v, act_v, sat_v;
    logic [31:0] exp_rpc;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_scnt;
    bit c, e;
    for (int cyc = 0; cyc < 500; cyc++) begin
      resetn         = ($urandom_range(0, 99) != 0);
      exc_valid      = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      exc_code       = (5*NS)'($urandom);
      exc_pc         = {$urandom, $urandom, $urandom};
      exc_bd         = NS'($urandom);
      int_pc         = $urandom;
      int_bd         = 1'($urandom);
      if ($urandom_range(0, 7) == 0) hw_int = NH'($urandom);
      if ($urandom_range(0, 7) == 0) cp0_status_im = NH'($urandom);
      cp0_status_ie  = ($urandom_range(0, 3) != 0);
      cp0_status_exl = ($urandom_range(0, 7) == 0);
      eret           = ($urandom_range(0, 3) == 0);
      cp0_epc_in     = $urandom;
      tick();
      c = (m_mode == M_COMMIT);
      e = (m_mode == M_ERET);
      exp_rpc  = c ? VEC : (e ? cp0_epc_in : 32'h0);
      exp_cnt  = (m_commits > 65535) ? 16'hFFFF : 16'(m_commits);
      exp_scnt = (m_commits > 15) ? 4'hF : 4'(m_commits);
      exp_v = {c, c & m_pend, m_code, m_epc, m_bd, m_ip, c | e, c | e, exp_rpc, m_mode == M_HANDLER};
      act_v = {cp0_we, cp0_epc_we, cp0_exccode, cp0_epc, cp0_bd, cp0_ip, flush, redirect_valid, redirect_pc, in_handler};
      sat_v = {s_we, s_epc_we, s_exccode, s_epc, s_bd, s_ip, s_flush, s_rv, s_rpc, s_in_handler};
      n_tests++; if (act_v !== exp_v || exc_count !== exp_cnt) begin
        n_fail++; $display("FAIL random_main cyc=%0d: got %h cnt=%0d want %h cnt=%0d", cyc, act_v, exc_count, exp_v, exp_cnt); end
      n_tests++; if (sat_v !== exp_v || s_count !== exp_scnt) begin
        n_fail++; $display("FAIL random_narrow cyc=%0d: got %h cnt=%0d want %h cnt=%0d", cyc, sat_v, s_count, exp_v, exp_scnt); end
    end
  endtask

  initial begin
    test_reset();
    test_exc_priority();
    test_exc_bd();
    test_interrupt();
    test_nested();
    test_eret();
    test_reset_in_commit();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_arbiter_n.md
Name: exc_arbiter_n

Overview:
- Parametrised, registered successor to the multi-cycle CPU's combinational exception/interrupt priority logic.
- Accepts exception reports from NUM_STAGES pipeline stages and NUM_HWINT hardware interrupt lines.
- Arbitrates them, then issues a one-cycle commit (CP0 write, pipeline flush, fetch redirect) through a small FSM. The FSM also tracks handler residency and ERET return.
- Sits between the pipeline stages, CP0 and Fetch.

Parameters:
- NUM_STAGES, 3, number of stage exception reporters; index 0 is the oldest stage and has the highest priority.
- NUM_HWINT, 6, number of hardware interrupt lines.
- PC_W, 32, PC/EPC width.
- EXC_VECTOR, 32'h8000_0180, general exception entry address.
- CNT_W, 16, width of the exception statistics counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- exc_valid  in  NUM_STAGES  per-stage exception flag
- exc_code  in  5*NUM_STAGES  per-stage ExcCode; slice i = [5i+4:5i]
- exc_pc  in  PC_W*NUM_STAGES  per-stage faulting PC
- exc_bd  in  NUM_STAGES  per-stage branch-delay-slot flag
- int_pc  in  PC_W  PC of the oldest uncommitted instruction (interrupt restart point)
- int_bd  in  1  int_pc is in a delay slot
- hw_int  in  NUM_HWINT  asynchronous interrupt lines
- cp0_status_ie  in  1  Status.IE
- cp0_status_exl  in  1  Status.EXL
- cp0_status_im  in  NUM_HWINT  Status.IM
- cp0_epc_in  in  PC_W  current EPC, used for ERET
- eret  in  1  ERET reached commit point (1-cycle pulse)
- cp0_we  out  1  write Cause/Status.EXL
- cp0_epc_we  out  1  write EPC/Cause.BD
- cp0_exccode  out  5  ExcCode for Cause
- cp0_epc  out  PC_W  EPC value
- cp0_bd  out  1  Cause.BD value
- cp0_ip  out  NUM_HWINT  synchronised pending lines for Cause.IP
- flush  out  1  pipeline flush pulse
- redirect_valid  out  1  Fetch redirect pulse
- redirect_pc  out  PC_W  redirect target
- in_handler  out  1  FSM is in HANDLER
- exc_count  out  CNT_W  saturating count of committed exceptions and interrupts

Behaviour:
- Reset: state IDLE, synchroniser flops 0, all outputs 0, exc_count 0. A reset during COMMIT or ERET drops every pulse on the next edge.
- cp0_ip = hw_int after a 2-flop synchroniser, so there are 2 cycles of latency.
- int_req = |(cp0_ip & cp0_status_im) & cp0_status_ie & ~cp0_status_exl & (state==IDLE).
- Winner: the lowest index i with exc_valid[i]=1. An interrupt is considered only when exc_valid==0.
  - Exception: code = exc_code slice i; epc = exc_bd[i] ? exc_pc_i - 4 : exc_pc_i; bd = exc_bd[i].
  - Interrupt: code = 0; epc = int_bd ? int_pc - 4 : int_pc; bd = int_bd.
- Winner fields are captured into registers on the detecting edge. Outputs are valid in the following cycle, giving 1-cycle latency.
- States:
  - IDLE: exc_valid≠0 or int_req → COMMIT with epc_we_pending=1. Otherwise eret → ERET.
  - COMMIT (exactly 1 cycle):
    - cp0_we=flush=redirect_valid=1; redirect_pc=EXC_VECTOR.
    - cp0_epc_we = epc_we_pending.
    - exc_count increments and saturates at all-ones.
    - Next state is HANDLER. All inputs are ignored this cycle.
  - HANDLER: in_handler=1 and interrupts are blocked.
    - exc_valid≠0 → COMMIT with epc_we_pending=0. This is the nested case: EPC/BD are preserved and the code is updated.
    - Otherwise eret → ERET.
  - ERET (exactly 1 cycle): flush=redirect_valid=1; redirect_pc = cp0_epc_in sampled in this cycle. Next state is IDLE.
- A simultaneous exc_valid and eret: the exception wins and eret is dropped.
- cp0_exccode, cp0_epc and cp0_bd hold their last committed values between commits.
- Outside COMMIT and ERET, flush, redirect_valid, cp0_we and cp0_epc_we are 0.
- PC arithmetic is modulo 2^PC_W.

Decomposition:
- Shared package exc_pkg holds:
  - the ExcCode constants INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OVF=12;
  - the state encoding IDLE/COMMIT/HANDLER/ERET;
  - EXC_VECTOR default.
- One sub-module, exc_prio_sel: a parametrised lowest-index priority encoder returning the winner index and a one-hot grant. It is used for stage selection.

Test Plan:
- exc_valid=3'b110, stage1 code=12, pc=0x400, bd=0; stage2 code=10 → next cycle: cp0_exccode=12, cp0_epc=0x400, cp0_epc_we=1, flush=1, redirect_pc=0x80000180. The cycle after that: in_handler=1, exc_count=1.
- Only stage0 valid: code=4, pc=0x1000, bd=1 → cp0_epc=0xFFC, cp0_bd=1.
- hw_int[2]=1, im=6'b000100, ie=1, exl=0, int_pc=0x2000 → commit 3 cycles after the assertion with cp0_exccode=0 and cp0_epc=0x2000. Repeat with im=0 → no commit.
- Interrupt during HANDLER → no commit. Then stage1 valid with code=10 → COMMIT with cp0_epc_we=0, cp0_exccode=10, cp0_epc unchanged.
- In HANDLER, eret with cp0_epc_in=0x3004 → 1-cycle flush and redirect to 0x3004, then IDLE. Repeat with eret and exc_valid in the same cycle → exception commits and ERET is skipped.
- resetn=0 during COMMIT → all outputs 0 on the next cycle and state IDLE. Preload exc_count to 16'hFFFF via 65535 commits (or force) → stays 16'hFFFF after one more commit.
